// File: rtl/imem_loader_pkg.sv
// Shared types and default geometry for the instruction-memory loader.
package instr_pack;

    localparam int DEF_SIZE = 1024;
    localparam int DEF_AW   = 10;
    localparam int DEF_CW   = 16;
    localparam int IW       = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } ldr_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader word stream plus the instruction-memory write port it drives.
interface imem_loader_if
    import instr_pack::*;
#(
    parameter int AW = DEF_AW
);
    logic          ld_valid;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [IW-1:0] im_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, then releases the CPU and
// times its run until it reports completion.
module imem_loader
    import instr_pack::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int AW   = DEF_AW,
    parameter int CW   = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          go,
    input  logic          cpu_done,
    imem_loader_if.slave  ldr,
    output logic          cpu_hold,
    output logic          cpu_start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   prog_len,
    output logic [CW-1:0] run_cycles
);
    ldr_state_t    state_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   prog_len_q;
    logic          err_q;
    logic          ld_ready_q;
    logic          cpu_start_q;
    logic          cpu_hold_q;
    logic          busy_q;
    logic          done_q;

    logic          go_acc;
    logic          xfer;
    logic          at_end;

    // Qualify with reset_n so nothing leaks out while reset is held low.
    assign ldr.ld_ready = ld_ready_q & reset_n;
    assign xfer         = ldr.ld_valid & ldr.ld_ready;
    assign ldr.im_we    = xfer;
    assign ldr.im_addr  = ptr_q;
    assign ldr.im_wdata = ldr.ld_data;
    assign at_end       = (ptr_q == AW'(SIZE - 1));

    assign go_acc = go && reset_n && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            prog_len_q  <= '0;
            err_q       <= 1'b0;
            ld_ready_q  <= 1'b0;
            cpu_start_q <= 1'b0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state_q    <= ST_LOAD;
                        ptr_q      <= '0;
                        prog_len_q <= '0;
                        err_q      <= 1'b0;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        prog_len_q <= prog_len_q + (AW+1)'(1);
                        // The pointer parks on the last slot rather than wrapping.
                        if (!at_end) begin
                            ptr_q <= ptr_q + AW'(1);
                        end
                        if (ldr.ld_last) begin
                            state_q     <= ST_START;
                            ld_ready_q  <= 1'b0;
                            cpu_start_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else if (at_end) begin
                            state_q    <= ST_DONE;
                            ld_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_q     <= ST_RUN;
                    cpu_start_q <= 1'b0;
                end
                ST_RUN: begin
                    if (cpu_done) begin
                        state_q    <= ST_DONE;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CW)
    ) u_run_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (go_acc),
        .en      (state_q == ST_RUN),
        .cnt     (run_cycles)
    );

    assign cpu_start = cpu_start_q & reset_n;
    assign cpu_hold  = cpu_hold_q | ~reset_n;
    assign busy      = busy_q & reset_n;
    assign done      = done_q & reset_n;
    assign err       = err_q;
    assign prog_len  = prog_len_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 16-word instance for overflow.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        go, go_s;
    logic        cpu_done, cpu_done_s;
    logic        cpu_hold, cpu_start, busy, done, err;
    logic        cpu_hold_s, cpu_start_s, busy_s, done_s, err_s;
    logic [10:0] prog_len;
    logic [4:0]  prog_len_s;
    logic [15:0] run_cycles, run_cycles_s;
    int          n_checks = 0;
    int          n_pass = 0;
    int          start_cnt = 0;
    int          start_cnt_s = 0;

    imem_loader_if #(.AW(10)) bus ();
    imem_loader_if #(.AW(4))  bus_s ();

    imem_loader dut (
        .clk(clk), .reset_n(reset_n), .go(go), .cpu_done(cpu_done), .ldr(bus.slave),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy), .done(done), .err(err),
        .prog_len(prog_len), .run_cycles(run_cycles)
    );

    imem_loader #(.SIZE(16), .AW(4), .CW(16)) dut_s (
        .clk(clk), .reset_n(reset_n), .go(go_s), .cpu_done(cpu_done_s), .ldr(bus_s.slave),
        .cpu_hold(cpu_hold_s), .cpu_start(cpu_start_s), .busy(busy_s), .done(done_s), .err(err_s),
        .prog_len(prog_len_s), .run_cycles(run_cycles_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_start === 1'b1) start_cnt++;
        if (cpu_start_s === 1'b1) start_cnt_s++;
    end

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.ld_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %b want 0", bus.ld_ready); else n_pass++;
        n_checks++; if (bus.im_we !== 1'b0) $display("FAIL rst_im_we: got %b want 0", bus.im_we); else n_pass++;
        n_checks++; if (cpu_start !== 1'b0) $display("FAIL rst_cpu_start: got %b want 0", cpu_start); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done: got %b%b want 00", busy, done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_checks++; if (prog_len !== 11'd0) $display("FAIL rst_prog_len: got %0d want 0", prog_len); else n_pass++;
        n_checks++; if (run_cycles !== 16'd0) $display("FAIL rst_run_cycles: got %0d want 0", run_cycles); else n_pass++;
        n_checks++; if (cpu_hold_s !== 1'b1 || busy_s !== 1'b0) $display("FAIL rst_small: hold=%b busy=%b want 1 0", cpu_hold_s, busy_s); else n_pass++;
        bus.ld_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || bus.ld_ready !== 1'b0) $display("FAIL idle_after_rst: busy=%b ready=%b want 0 0", busy, bus.ld_ready); else n_pass++;
    endtask

    task automatic test_load_run();
        logic [8:0] w [3];
        int base;
        w[0] = 9'h1AF; w[1] = 9'h000; w[2] = 9'h0F3;
        base = start_cnt;
        pulse_go();
        #1;
        n_checks++; if (bus.ld_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL load_entry: ready=%b busy=%b hold=%b want 1 1 1", bus.ld_ready, busy, cpu_hold); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1; bus.ld_data = w[i]; bus.ld_last = (i == 2);
            #1;
            n_checks++; if (bus.im_we !== 1'b1 || bus.im_addr !== 10'(i) || bus.im_wdata !== w[i])
                $display("FAIL load_wr%0d: we=%b addr=%0d data=%h want 1 %0d %h", i, bus.im_we, bus.im_addr, bus.im_wdata, i, w[i]); else n_pass++;
            @(negedge clk);
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        #1;
        n_checks++; if (cpu_start !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL start_state: start=%b hold=%b want 1 0", cpu_start, cpu_hold); else n_pass++;
        n_checks++; if (prog_len !== 11'd3) $display("FAIL load_prog_len: got %0d want 3", prog_len); else n_pass++;
        n_checks++; if (bus.im_we !== 1'b0 || bus.ld_ready !== 1'b0) $display("FAIL start_no_write: we=%b ready=%b want 0 0", bus.im_we, bus.ld_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (cpu_start !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b1) $display("FAIL run_entry: start=%b hold=%b busy=%b want 0 0 1", cpu_start, cpu_hold, busy); else n_pass++;
        n_checks++; if (start_cnt - base !== 1) $display("FAIL start_pulses: got %0d want 1", start_cnt - base); else n_pass++;
        repeat (9) @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL run_done: done=%b busy=%b hold=%b want 1 0 1", done, busy, cpu_hold); else n_pass++;
        n_checks++; if (run_cycles !== 16'd10) $display("FAIL run_cycles10: got %0d want 10", run_cycles); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (run_cycles !== 16'd10 || prog_len !== 11'd3) $display("FAIL done_hold: run=%0d len=%0d want 10 3", run_cycles, prog_len); else n_pass++;
    endtask

    task automatic test_valid_toggle();
        int exp_addr;
        exp_addr = 0;
        pulse_go();
        #1;
        n_checks++; if (prog_len !== 11'd0 || run_cycles !== 16'd0) $display("FAIL go_clear: len=%0d run=%0d want 0 0", prog_len, run_cycles); else n_pass++;
        cpu_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = (i % 2 == 0); bus.ld_data = 9'h100 + 9'(i); bus.ld_last = (i == 4);
            #1;
            if (i % 2 == 0) begin
                n_checks++; if (bus.im_we !== 1'b1 || bus.im_addr !== 10'(exp_addr))
                    $display("FAIL toggle_wr%0d: we=%b addr=%0d want 1 %0d", i, bus.im_we, bus.im_addr, exp_addr); else n_pass++;
                exp_addr++;
            end else begin
                n_checks++; if (bus.im_we !== 1'b0 || bus.ld_ready !== 1'b1)
                    $display("FAIL toggle_idle%0d: we=%b ready=%b want 0 1", i, bus.im_we, bus.ld_ready); else n_pass++;
            end
            @(negedge clk);
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        #1;
        n_checks++; if (cpu_start !== 1'b1 || prog_len !== 11'd3) $display("FAIL toggle_start: start=%b len=%0d want 1 3", cpu_start, prog_len); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL done_ignored_start: busy=%b done=%b want 1 0", busy, done); else n_pass++;
        @(negedge clk);
        cpu_done = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1 || run_cycles !== 16'd1) $display("FAIL toggle_run1: done=%b run=%0d want 1 1", done, run_cycles); else n_pass++;
    endtask

    task automatic test_go_in_run();
        pulse_go();
        bus.ld_valid = 1'b1; bus.ld_data = 9'h0AA; bus.ld_last = 1'b1;
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1 || bus.ld_ready !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL go_ignored_run: busy=%b ready=%b hold=%b want 1 0 0", busy, bus.ld_ready, cpu_hold); else n_pass++;
        go = 1'b1; cpu_done = 1'b1;
        @(negedge clk);
        go = 1'b0; cpu_done = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.ld_ready !== 1'b0) $display("FAIL done_over_go: done=%b busy=%b ready=%b want 1 0 0", done, busy, bus.ld_ready); else n_pass++;
        n_checks++; if (run_cycles !== 16'd2 || prog_len !== 11'd1) $display("FAIL run2_len1: run=%0d len=%0d want 2 1", run_cycles, prog_len); else n_pass++;
        pulse_go();
        #1;
        n_checks++; if (prog_len !== 11'd0 || run_cycles !== 16'd0 || err !== 1'b0 || bus.ld_ready !== 1'b1)
            $display("FAIL second_go: len=%0d run=%0d err=%b ready=%b want 0 0 0 1", prog_len, run_cycles, err, bus.ld_ready); else n_pass++;
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = 1'b1; bus.ld_data = 9'h050 + 9'(i); bus.ld_last = 1'b0;
            #1;
            n_checks++; if (bus.im_addr !== 10'(i) || bus.im_we !== 1'b1) $display("FAIL abort_wr%0d: we=%b addr=%0d want 1 %0d", i, bus.im_we, bus.im_addr, i); else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++; if (prog_len !== 11'd5) $display("FAIL abort_len5: got %0d want 5", prog_len); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.im_we !== 1'b0 || bus.ld_ready !== 1'b0) $display("FAIL abort_rst_we: we=%b ready=%b want 0 0", bus.im_we, bus.ld_ready); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1; bus.ld_valid = 1'b0;
        #1;
        n_checks++; if (prog_len !== 11'd0 || busy !== 1'b0 || cpu_hold !== 1'b1 || bus.ld_ready !== 1'b0)
            $display("FAIL abort_idle: len=%0d busy=%b hold=%b ready=%b want 0 0 1 0", prog_len, busy, cpu_hold, bus.ld_ready); else n_pass++;
        pulse_go();
        bus.ld_valid = 1'b1; bus.ld_data = 9'h1FF; bus.ld_last = 1'b1;
        #1;
        n_checks++; if (bus.im_we !== 1'b1 || bus.im_addr !== 10'd0 || bus.im_wdata !== 9'h1FF)
            $display("FAIL restart_wr: we=%b addr=%0d data=%h want 1 0 1ff", bus.im_we, bus.im_addr, bus.im_wdata); else n_pass++;
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
    endtask

    task automatic test_overflow();
        go_s = 1'b1;
        @(negedge clk);
        go_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_s.ld_valid = 1'b1; bus_s.ld_data = 9'h0A0 + 9'(i); bus_s.ld_last = 1'b0;
            #1;
            n_checks++; if (bus_s.im_we !== 1'b1 || bus_s.im_addr !== 4'(i)) $display("FAIL ovf_wr%0d: we=%b addr=%0d want 1 %0d", i, bus_s.im_we, bus_s.im_addr, i); else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++; if (err_s !== 1'b1 || done_s !== 1'b1 || busy_s !== 1'b0) $display("FAIL ovf_state: err=%b done=%b busy=%b want 1 1 0", err_s, done_s, busy_s); else n_pass++;
        n_checks++; if (prog_len_s !== 5'd16) $display("FAIL ovf_len: got %0d want 16", prog_len_s); else n_pass++;
        n_checks++; if (bus_s.im_we !== 1'b0 || bus_s.ld_ready !== 1'b0 || cpu_hold_s !== 1'b1)
            $display("FAIL ovf_stop: we=%b ready=%b hold=%b want 0 0 1", bus_s.im_we, bus_s.ld_ready, cpu_hold_s); else n_pass++;
        n_checks++; if (start_cnt_s !== 0) $display("FAIL ovf_no_start: got %0d want 0", start_cnt_s); else n_pass++;
        @(negedge clk);
        bus_s.ld_valid = 1'b0;
        go_s = 1'b1;
        @(negedge clk);
        go_s = 1'b0;
        #1;
        n_checks++; if (err_s !== 1'b0 || prog_len_s !== 5'd0 || busy_s !== 1'b1) $display("FAIL ovf_go_clear: err=%b len=%0d busy=%b want 0 0 1", err_s, prog_len_s, busy_s); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        go = 1'b0; go_s = 1'b0;
        cpu_done = 1'b0; cpu_done_s = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
        bus_s.ld_valid = 1'b0; bus_s.ld_data = '0; bus_s.ld_last = 1'b0;
        test_reset();
        test_load_run();
        test_valid_toggle();
        test_go_in_run();
        test_abort();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
